// File: rtl/uart_word_receiver.sv
// Oversampling UART receiver that packs the low nibbles of four frames into a 16-bit word.
// Optional UART_RX_PARITY_EN adds an even parity bit per frame (8E1); otherwise frames are 8N1.
`timescale 1ns/1ps
module uart_word_receiver #(
  parameter int unsigned DIV0     = 10417,
  parameter int unsigned DIV1     = 2604,
  parameter int unsigned DIV2     = 651,
  parameter int unsigned DIV3     = 326,
  parameter int unsigned DIV4     = 163,
  parameter int unsigned DIV5     = 81,
  parameter int unsigned DIV6     = 54,
  parameter int unsigned DIV7     = 27,
  parameter int unsigned GAP_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  baud_select,
  input  logic        rx_en,
  input  logic        RxD,
  output logic [15:0] word,
  output logic        word_valid,
  output logic        perror,
  output logic        ferror,
  output logic        busy
);

  // state    | meaning
  // S_IDLE   | waiting for a falling edge on the synchronized line
  // S_START  | timing to the start-bit centre to reject glitches
  // S_DATA   | sampling 8 data bits, LSB first
  // S_PARITY | sampling the even parity bit (parity builds only)
  // S_STOP   | sampling the stop bit and committing the nibble
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  localparam state_t S_AFTER_DATA = S_PARITY;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  localparam state_t S_AFTER_DATA = S_STOP;
`endif

  localparam int unsigned GAP_TICKS = GAP_BITS * 16;
  localparam int unsigned GW        = $clog2(GAP_TICKS + 1);

  state_t state_q, state_d;
  logic rxd_meta_q, rxd_meta_d, rxd_sync_q, rxd_sync_d, rxd_prev_q, rxd_prev_d;
  logic [2:0]  baud_q, baud_d;
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]  samp_cnt_q, samp_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_err_q, par_err_d;
  logic [1:0]  idx_q, idx_d;
  logic [11:0] staging_q, staging_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [15:0] word_q, word_d;
  logic        word_valid_q, word_valid_d, perror_q, perror_d, ferror_q, ferror_d;
  logic        start_det, tick, sample;
  logic [15:0] div_val;

  function automatic logic [15:0] div_of(input logic [2:0] sel);
    case (sel)
      3'd0:    return 16'(DIV0);
      3'd1:    return 16'(DIV1);
      3'd2:    return 16'(DIV2);
      3'd3:    return 16'(DIV3);
      3'd4:    return 16'(DIV4);
      3'd5:    return 16'(DIV5);
      3'd6:    return 16'(DIV6);
      default: return 16'(DIV7);
    endcase
  endfunction

  // The rate is only frozen while a frame is in flight; idle ticks feed the gap timer.
  assign div_val   = div_of((state_q == S_IDLE) ? baud_select : baud_q);
  assign start_det = (state_q == S_IDLE) && rx_en && rxd_prev_q && !rxd_sync_q;
  assign tick      = (tick_cnt_q == 16'd0);
  assign sample    = (state_q != S_IDLE) && tick && (samp_cnt_q == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_det) state_d = S_START;
      S_START:  if (sample) state_d = rxd_sync_q ? S_IDLE : S_DATA;
      S_DATA:   if (sample && bit_cnt_q == 3'd7) state_d = S_AFTER_DATA;
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (sample) state_d = S_STOP;
`endif
      S_STOP:   if (sample) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (!rx_en) state_d = S_IDLE;
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    word       = word_q;
    word_valid = word_valid_q;
    ferror     = ferror_q;
`ifdef UART_RX_PARITY_EN
    perror     = perror_q;
`else
    perror     = 1'b0;
`endif
  end

  always_comb begin
    rxd_meta_d   = RxD;
    rxd_sync_d   = rxd_meta_q;
    rxd_prev_d   = rxd_sync_q;
    baud_d       = baud_q;
    tick_cnt_d   = (start_det || tick) ? div_val - 16'd1 : tick_cnt_q - 16'd1;
    samp_cnt_d   = samp_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_err_d    = par_err_q;
    idx_d        = idx_q;
    staging_d    = staging_q;
    gap_cnt_d    = '0;
    word_d       = word_q;
    word_valid_d = 1'b0;
    perror_d     = 1'b0;
    ferror_d     = 1'b0;

    if (state_q != S_IDLE && tick) samp_cnt_d = (samp_cnt_q == 4'd0) ? 4'd15 : samp_cnt_q - 4'd1;

    if (state_q == S_IDLE && idx_q != 2'd0) begin
      gap_cnt_d = gap_cnt_q;
      if (tick) begin
        if (gap_cnt_q == GW'(GAP_TICKS - 1)) begin
          gap_cnt_d = '0;
          idx_d     = 2'd0;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
    end

    if (start_det) begin
      baud_d     = baud_select;
      samp_cnt_d = 4'd7;
      gap_cnt_d  = '0;
    end

    if (sample) begin
      case (state_q)
        S_START: begin
          bit_cnt_d = 3'd0;
          par_err_d = 1'b0;
        end
        S_DATA: begin
          shift_d   = {rxd_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: par_err_d = rxd_sync_q ^ (^shift_q);
`endif
        S_STOP: begin
          if (!rxd_sync_q) begin
            ferror_d = 1'b1;
            idx_d    = 2'd0;
          end else if (par_err_q) begin
            perror_d = 1'b1;
            idx_d    = 2'd0;
          end else begin
            case (idx_q)
              2'd0: staging_d[11:8] = shift_q[3:0];
              2'd1: staging_d[7:4]  = shift_q[3:0];
              2'd2: staging_d[3:0]  = shift_q[3:0];
              default: begin
                word_d       = {staging_q, shift_q[3:0]};
                word_valid_d = 1'b1;
              end
            endcase
            idx_d = idx_q + 2'd1;
          end
        end
        default: ;
      endcase
    end

    if (!rx_en) begin
      idx_d        = 2'd0;
      gap_cnt_d    = '0;
      word_valid_d = 1'b0;
      perror_d     = 1'b0;
      ferror_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta_q   <= 1'b1;
      rxd_sync_q   <= 1'b1;
      rxd_prev_q   <= 1'b1;
      baud_q       <= 3'd0;
      tick_cnt_q   <= 16'd0;
      samp_cnt_q   <= 4'd0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      par_err_q    <= 1'b0;
      idx_q        <= 2'd0;
      staging_q    <= 12'd0;
      gap_cnt_q    <= '0;
      word_q       <= 16'd0;
      word_valid_q <= 1'b0;
      perror_q     <= 1'b0;
      ferror_q     <= 1'b0;
    end else begin
      rxd_meta_q   <= rxd_meta_d;
      rxd_sync_q   <= rxd_sync_d;
      rxd_prev_q   <= rxd_prev_d;
      baud_q       <= baud_d;
      tick_cnt_q   <= tick_cnt_d;
      samp_cnt_q   <= samp_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_err_q    <= par_err_d;
      idx_q        <= idx_d;
      staging_q    <= staging_d;
      gap_cnt_q    <= gap_cnt_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      perror_q     <= perror_d;
      ferror_q     <= ferror_d;
    end
  end

endmodule

// File: tb/tb_uart_word_receiver.sv
// Self-checking bench for uart_word_receiver: frame-level reference model plus vector table.
// Works for both settings of UART_RX_PARITY_EN; small divisors keep runtime short.
`timescale 1ns/1ps
module tb_uart_word_receiver;

  localparam int D0 = 20, D5 = 7, D7 = 4, GAP = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  baud_select = 3'd7;
  logic        rx_en = 1'b1;
  logic        RxD = 1'b1;
  logic [15:0] word;
  logic        word_valid, perror, ferror, busy;

  uart_word_receiver #(
    .DIV0(D0), .DIV1(12), .DIV2(10), .DIV3(9), .DIV4(8), .DIV5(D5), .DIV6(5), .DIV7(D7),
    .GAP_BITS(GAP)
  ) dut (
    .clk(clk), .reset(reset), .baud_select(baud_select), .rx_en(rx_en), .RxD(RxD),
    .word(word), .word_valid(word_valid), .perror(perror), .ferror(ferror), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int          m_idx = 0;
  logic [15:0] m_stage = 16'h0;
  logic [15:0] m_last = 16'h0;
  logic [15:0] exp_words[$];
  int          exp_perr = 0, exp_ferr = 0;

  // observed strobes
  logic [15:0] got_words[$];
  int          got_perr = 0, got_ferr = 0;

  typedef struct {
    logic [31:0] bytes;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (word_valid) got_words.push_back(word);
    if (perror) got_perr++;
    if (ferror) got_ferr++;
    if (word_valid || perror || ferror) begin
      n_checks++;
      if (32'(word_valid) + 32'(perror) + 32'(ferror) > 1) begin
        n_fail++;
        $display("FAIL strobe_onehot: got v=%0b p=%0b f=%0b expected at most one", word_valid, perror, ferror);
      end
    end
  end

  task automatic model_frame(input logic [7:0] d, input bit flip, input bit bad_stop);
    bit par_bad = 1'b0;
    int sh;
`ifdef UART_RX_PARITY_EN
    par_bad = flip;
`endif
    if (bad_stop) begin
      exp_ferr++;
      m_idx = 0;
    end else if (par_bad) begin
      exp_perr++;
      m_idx = 0;
    end else begin
      sh = 12 - 4 * m_idx;
      m_stage = (m_stage & ~(16'hF << sh)) | ({12'h0, d[3:0]} << sh);
      m_idx++;
      if (m_idx == 4) begin
        exp_words.push_back(m_stage);
        m_last = m_stage;
        m_idx = 0;
      end
    end
  endtask

  task automatic hold(input logic v, input int n);
    RxD = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit flip, input bit bad_stop,
                            input int div, input int gap_bits);
    int bc = 16 * div;
    hold(1'b0, bc);
    for (int i = 0; i < 8; i++) begin
      RxD = d[i];
      repeat (bc / 2) @(negedge clk);
      if (i == 4 && rx_en) chk("busy_mid_frame", 32'(busy), 32'd1);
      repeat (bc - bc / 2) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    hold((^d) ^ flip, bc);
`endif
    hold(!bad_stop, bc);
    hold(1'b1, gap_bits * bc);
    model_frame(d, flip, bad_stop);
  endtask

  task automatic send_partial(input logic [7:0] d, input int nbits, input int div);
    int bc = 16 * div;
    hold(1'b0, bc);
    for (int i = 0; i < nbits; i++) hold(d[i], bc);
    RxD = d[nbits];
    repeat (bc / 2) @(negedge clk);
  endtask

  task automatic check_results(input string name);
    int n;
    repeat (4) @(negedge clk);
    chk({name, "_nwords"}, got_words.size(), exp_words.size());
    n = (got_words.size() < exp_words.size()) ? got_words.size() : exp_words.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_word%0d", name, i), 32'(got_words[i]), 32'(exp_words[i]));
    chk({name, "_perror"}, got_perr, exp_perr);
    chk({name, "_ferror"}, got_ferr, exp_ferr);
    chk({name, "_word_out"}, 32'(word), 32'(m_last));
    got_words.delete();
    exp_words.delete();
    got_perr = 0; got_ferr = 0; exp_perr = 0; exp_ferr = 0;
  endtask

  initial begin
    tbl[0] = '{32'h0C0C0100, 16'hCC10};
    tbl[1] = '{32'hFA3B5C9D, 16'hABCD};
    tbl[2] = '{32'hFFF00F81, 16'hF0F1};
    tbl[3] = '{32'h12345678, 16'h2468};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_word", 32'(word), 32'h0);
    chk("reset_valid", 32'(word_valid), 32'd0);
    chk("reset_perror", 32'(perror), 32'd0);
    chk("reset_ferror", 32'(ferror), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);

    // framing error on the second frame
    send_frame(8'h0C, 0, 0, D7, 2);
    send_frame(8'h0C, 0, 1, D7, 2);
    check_results("framing");
    chk("framing_word_zero", 32'(word), 32'h0);

    // short low glitch must be rejected at the start-bit centre
    baud_select = 3'd0;
    repeat (5) @(negedge clk);
    RxD = 1'b0;
    repeat (50) @(negedge clk);
    chk("glitch_busy_start", 32'(busy), 32'd1);
    repeat (50) @(negedge clk);
    RxD = 1'b1;
    repeat (150) @(negedge clk);
    chk("glitch_busy_rejected", 32'(busy), 32'd0);
    check_results("glitch");
    baud_select = 3'd7;
    repeat (10) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      for (int b = 3; b >= 0; b--) send_frame(tbl[v].bytes[8*b +: 8], 0, 0, D7, 2);
      repeat (2) @(negedge clk);
      chk($sformatf("table%0d_word", v), 32'(word), 32'(tbl[v].exp));
      check_results($sformatf("table%0d", v));
    end

`ifdef UART_RX_PARITY_EN
    send_frame(8'h0C, 0, 0, D7, 2);
    send_frame(8'h0C, 1, 0, D7, 2);
    send_frame(8'h01, 0, 0, D7, 2);
    send_frame(8'h00, 0, 0, D7, 2);
    send_frame(8'h0C, 0, 0, D7, 2);
    send_frame(8'h0D, 0, 0, D7, 2);
    chk("parity_word", 32'(word), 32'h10CD);
    check_results("parity");
`endif

    // inter-frame gap timeout discards the partial word
    send_frame(8'h01, 0, 0, D7, 2);
    send_frame(8'h02, 0, 0, D7, 40);
    m_idx = 0;
    send_frame(8'h0A, 0, 0, D7, 2);
    send_frame(8'h0B, 0, 0, D7, 2);
    send_frame(8'h0C, 0, 0, D7, 2);
    send_frame(8'h0D, 0, 0, D7, 2);
    chk("gap_word", 32'(word), 32'hABCD);
    check_results("gap");

    // synchronous reset in the middle of frame 3 data
    send_frame(8'h01, 0, 0, D7, 2);
    send_frame(8'h02, 0, 0, D7, 2);
    send_partial(8'h00, 3, D7);
    RxD = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_reset_word", 32'(word), 32'h0);
    chk("abort_reset_busy", 32'(busy), 32'd0);
    chk("abort_reset_strobes", {29'd0, word_valid, perror, ferror}, 32'd0);
    reset = 1'b0;
    m_idx = 0;
    m_last = 16'h0;
    repeat (4 * 16 * D7) @(negedge clk);
    check_results("abort_reset");

    // rx_en drop mid-frame clears the index and keeps the word
    for (int b = 5; b <= 8; b++) send_frame(8'(b), 0, 0, D7, 2);
    send_frame(8'h09, 0, 0, D7, 2);
    send_partial(8'h00, 3, D7);
    rx_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("rxen_busy", 32'(busy), 32'd0);
    RxD = 1'b1;
    repeat (2 * 16 * D7) @(negedge clk);
    chk("rxen_word_held", 32'(word), 32'h5678);
    rx_en = 1'b1;
    m_idx = 0;
    repeat (16 * D7) @(negedge clk);
    for (int b = 1; b <= 4; b++) send_frame(8'(b), 0, 0, D7, 2);
    chk("rxen_next_word", 32'(word), 32'h1234);
    check_results("rx_en");

    // baud change during the 4th frame applies only to later frames
    send_frame(8'h0E, 0, 0, D7, 2);
    send_frame(8'h0D, 0, 0, D7, 2);
    send_frame(8'h0C, 0, 0, D7, 2);
    fork
      send_frame(8'h0B, 0, 0, D7, 2);
      begin
        repeat (3 * 16 * D7) @(negedge clk);
        baud_select = 3'd5;
      end
    join
    chk("baud_old_rate_word", 32'(word), 32'hEDCB);
    for (int b = 4; b >= 1; b--) send_frame(8'(b), 0, 0, D5, 2);
    chk("baud_new_rate_word", 32'(word), 32'h4321);
    check_results("baud");

    baud_select = 3'd7;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] d;
      int r;
      d = 8'($urandom);
      r = $urandom_range(0, 7);
      send_frame(d, r == 1, r == 0, D7, $urandom_range(1, 3));
    end
    check_results("random");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
